// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared widths, drive-mode codes, sequencer state encoding and the PWM slew
// helper for the motion ramp controller.
// -----------------------------------------------------------------------------
package motion_pkg;

   localparam int MODE_W = 5;
   localparam int PWM_W  = 8;

   // Drive modes understood by the wheel controller.
   localparam logic [MODE_W-1:0] MODE_STOP  = 5'd0;
   localparam logic [MODE_W-1:0] MODE_FWD   = 5'd1;
   localparam logic [MODE_W-1:0] MODE_BACK  = 5'd2;
   localparam logic [MODE_W-1:0] MODE_LEFT  = 5'd3;
   localparam logic [MODE_W-1:0] MODE_RIGHT = 5'd4;

   // Sequencer states.
   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_RAMP = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;
   localparam logic [1:0] ST_DEAD = 2'd3;

   // Unknown mode codes are treated as a stop request.
   function automatic logic [MODE_W-1:0] sanitise_mode(input logic [MODE_W-1:0] m);
      return (m > MODE_RIGHT) ? MODE_STOP : m;
   endfunction

   // One slew step from cur toward tgt. The 9-bit compare lands exactly on the
   // target when the remaining distance is under one step, so it never
   // overshoots and cannot wrap past 0 or 255.
   function automatic logic [PWM_W-1:0] slew_toward(input logic [PWM_W-1:0] cur,
                                                    input logic [PWM_W-1:0] tgt,
                                                    input logic [PWM_W:0]   step);
      logic [PWM_W:0]   c9;
      logic [PWM_W:0]   t9;
      logic [PWM_W-1:0] res;
      c9  = {1'b0, cur};
      t9  = {1'b0, tgt};
      res = cur;
      if (t9 > c9) begin
         if ((t9 - c9) < step) res = tgt;
         else                  res = PWM_W'(c9 + step);
      end else if (c9 > t9) begin
         if ((c9 - t9) < step) res = tgt;
         else                  res = PWM_W'(c9 - step);
      end
      return res;
   endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// -----------------------------------------------------------------------------
// ramp_tick_gen
// Free-running prescaler counting 0..DIV-1; tick is high during the terminal
// count. clr restarts the count so the next tick is a full DIV cycles away.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   clr   in  restart the count from 0 on the next edge
//   tick  out one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module ramp_tick_gen #(
   parameter int unsigned DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == TERM);

   // NOTE: next-state logic assigns cnt_d on every path, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) cnt_d = '0;
   end

   // NOTE: registers update with non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/motion_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motion_ramp_ctrl
// Sequencer between the command decoder and the H-bridge wheel controller.
// Slews pwm toward the commanded speed in STEP increments every RAMP_DIV
// cycles; on a mode change it ramps to zero, idles the bridge for DEAD_CYCLES,
// then switches mode and ramps back up. estop forces an immediate stop.
// Optional command watchdog: define MOTION_RAMP_WATCHDOG_EN.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_mode, cmd_speed requested mode (0..4) and target duty
//   estop               level-sensitive emergency stop
//   mode, pwm           drive to the wheel controller
//   busy                sequencer not settled in HOLD
//   at_speed            settled in HOLD at the target duty
//   wdt_trip            watchdog fired (sticky until next accepted command)
// -----------------------------------------------------------------------------
module motion_ramp_ctrl
   import motion_pkg::*;
#(
   parameter int unsigned RAMP_DIV    = 50000,
   parameter int unsigned STEP        = 4,
   parameter int unsigned DEAD_CYCLES = 100000,
   parameter int unsigned WDT_CYCLES  = 50000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [MODE_W-1:0] cmd_mode,
   input  logic [PWM_W-1:0]  cmd_speed,
   input  logic              estop,
   output logic [MODE_W-1:0] mode,
   output logic [PWM_W-1:0]  pwm,
   output logic              busy,
   output logic              at_speed,
   output logic              wdt_trip
);

   localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DW-1:0]   DEAD_TERM = DW'(DEAD_CYCLES - 1);
   localparam logic [PWM_W:0]  STEP9     = (PWM_W + 1)'(STEP);

   logic [1:0]        state_q, state_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [PWM_W-1:0]  pwm_q, pwm_d;
   logic [MODE_W-1:0] tgt_mode_q, tgt_mode_d;
   logic [PWM_W-1:0]  tgt_speed_q, tgt_speed_d;
   logic [DW-1:0]     dead_cnt_q, dead_cnt_d;
   logic              tick, prescale_clr, accept, wdt_fire;
   logic [MODE_W-1:0] cmd_mode_s;

   assign cmd_ready  = !estop && (state_q != ST_DEAD);
   assign accept     = cmd_valid && cmd_ready;
   assign cmd_mode_s = sanitise_mode(cmd_mode);

   assign mode     = mode_q;
   assign pwm      = pwm_q;
   assign busy     = (state_q != ST_HOLD);
   assign at_speed = (state_q == ST_HOLD) && (pwm_q == tgt_speed_q);

   // Restart the prescaler on entry to a slewing state so the first step is a
   // full RAMP_DIV cycles after entry.
   assign prescale_clr = ((state_d == ST_RAMP) || (state_d == ST_DOWN)) && (state_d != state_q);

   ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (prescale_clr),
      .tick  (tick)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pwm_d       = pwm_q;
      tgt_mode_d  = tgt_mode_q;
      tgt_speed_d = tgt_speed_q;
      dead_cnt_d  = dead_cnt_q;

      // Latest accepted command wins; a stop request always targets zero speed.
      if (accept) begin
         tgt_mode_d  = cmd_mode_s;
         tgt_speed_d = (cmd_mode_s == MODE_STOP) ? '0 : cmd_speed;
      end else if (wdt_fire) begin
         tgt_mode_d  = MODE_STOP;
         tgt_speed_d = '0;
      end

      case (state_q)
         ST_HOLD: begin
            if (tgt_mode_q != mode_q) begin
               if (pwm_q != '0) begin
                  state_d = ST_DOWN;
               end else begin
                  state_d    = ST_DEAD;
                  dead_cnt_d = '0;
               end
            end else if (tgt_speed_q != pwm_q) begin
               state_d = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (tgt_mode_q != mode_q)      state_d = ST_DOWN;
            else if (pwm_q == tgt_speed_q) state_d = ST_HOLD;
            else if (tick)                 pwm_d   = slew_toward(pwm_q, tgt_speed_q, STEP9);
         end
         ST_DOWN: begin
            if (pwm_q == '0) begin
               state_d    = ST_DEAD;
               dead_cnt_d = '0;
            end else if (tick) begin
               pwm_d = slew_toward(pwm_q, '0, STEP9);
            end
         end
         default: begin // ST_DEAD: bridge idle at pwm 0, old mode kept
            if (dead_cnt_q == DEAD_TERM) begin
               mode_d  = tgt_mode_q;
               state_d = (tgt_speed_q != '0) ? ST_RAMP : ST_HOLD;
            end else begin
               dead_cnt_d = dead_cnt_q + DW'(1);
            end
         end
      endcase

      // Emergency stop overrides everything; the dead time restarts from zero
      // for as long as estop stays high.
      if (estop) begin
         pwm_d       = '0;
         mode_d      = MODE_STOP;
         tgt_mode_d  = MODE_STOP;
         tgt_speed_d = '0;
         state_d     = ST_DEAD;
         dead_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HOLD;
         mode_q      <= MODE_STOP;
         pwm_q       <= '0;
         tgt_mode_q  <= MODE_STOP;
         tgt_speed_q <= '0;
         dead_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pwm_q       <= pwm_d;
         tgt_mode_q  <= tgt_mode_d;
         tgt_speed_q <= tgt_speed_d;
         dead_cnt_q  <= dead_cnt_d;
      end
   end

`ifdef MOTION_RAMP_WATCHDOG_EN
   localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
   localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
   localparam logic [WW-1:0] WDT_DONE = WW'(WDT_CYCLES);

   logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
   logic          wdt_trip_q, wdt_trip_d;

   // Fires once per silence period; the counter then parks at WDT_DONE.
   assign wdt_fire = !accept && (wdt_cnt_q == WDT_LAST);
   assign wdt_trip = wdt_trip_q;

   always_comb begin
      wdt_cnt_d  = wdt_cnt_q;
      wdt_trip_d = wdt_trip_q;
      if (accept) begin
         wdt_cnt_d  = '0;
         wdt_trip_d = 1'b0;
      end else if (wdt_cnt_q != WDT_DONE) begin
         wdt_cnt_d = wdt_cnt_q + WW'(1);
         if (wdt_fire) wdt_trip_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdt_cnt_q  <= '0;
         wdt_trip_q <= 1'b0;
      end else begin
         wdt_cnt_q  <= wdt_cnt_d;
         wdt_trip_q <= wdt_trip_d;
      end
   end
`else
   assign wdt_fire = 1'b0;
   assign wdt_trip = 1'b0;
`endif

endmodule

// File: tb/tb_motion_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motion_ramp_ctrl
// Directed bench for motion_ramp_ctrl with RAMP_DIV=4, STEP=16, DEAD_CYCLES=8,
// WDT_CYCLES=200. Inputs change and outputs are sampled 1 ns after posedge.
// -----------------------------------------------------------------------------
module tb_motion_ramp_ctrl;

   localparam int RAMP_DIV    = 4;
   localparam int STEP        = 16;
   localparam int DEAD_CYCLES = 8;
   localparam int WDT_CYCLES  = 200;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [4:0] cmd_mode  = '0;
   logic [7:0] cmd_speed = '0;
   logic       estop     = 1'b0;
   logic [4:0] mode;
   logic [7:0] pwm;
   logic       busy;
   logic       at_speed;
   logic       wdt_trip;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   motion_ramp_ctrl #(
      .RAMP_DIV    (RAMP_DIV),
      .STEP        (STEP),
      .DEAD_CYCLES (DEAD_CYCLES),
      .WDT_CYCLES  (WDT_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_speed (cmd_speed),
      .estop     (estop),
      .mode      (mode),
      .pwm       (pwm),
      .busy      (busy),
      .at_speed  (at_speed),
      .wdt_trip  (wdt_trip)
   );

   task automatic check(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one command for a single cycle; it is accepted on that edge.
   task automatic send(input int m, input int s);
      check("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_mode  = m[4:0];
      cmd_speed = s[7:0];
      step(1);
      cmd_valid = 1'b0;
      cmd_mode  = '0;
      cmd_speed = '0;
   endtask

   // Called on the first DEAD cycle; returns on the cycle after the mode switch.
   task automatic check_dead(input int m);
      for (int i = 0; i < DEAD_CYCLES; i++) begin
         check("dead_pwm", int'(pwm), 0);
         check("dead_mode", int'(mode), m);
         check("dead_ready", int'(cmd_ready), 0);
         check("dead_busy", int'(busy), 1);
         step(1);
      end
   endtask

   // Called on the cycle after entry to RAMP/DOWN; expects one step every
   // RAMP_DIV cycles, landing exactly on 'to'.
   task automatic expect_ramp(input int from, input int to, input int m);
      int exp_pwm;
      exp_pwm = from;
      while (exp_pwm != to) begin
         step(RAMP_DIV - 1);
         check("slew_hold", int'(pwm), exp_pwm);
         step(1);
         if (to > exp_pwm) exp_pwm = (to - exp_pwm < STEP) ? to : exp_pwm + STEP;
         else              exp_pwm = (exp_pwm - to < STEP) ? to : exp_pwm - STEP;
         check("slew_step", int'(pwm), exp_pwm);
         check("slew_mode", int'(mode), m);
         check("slew_busy", int'(busy), 1);
      end
   endtask

   initial begin
      #500us;
      $display("FAIL timeout: run did not finish, got time %0t, expected < 500us", $time);
      $fatal(1);
   end

   initial begin
      // Reset values.
      step(2);
      check("rst_mode", int'(mode), 0);
      check("rst_pwm", int'(pwm), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_at_speed", int'(at_speed), 1);
      check("rst_wdt", int'(wdt_trip), 0);
      check("rst_ready", int'(cmd_ready), 1);
      reset = 1'b0;
      step(2);
      check("idle_busy", int'(busy), 0);

      // From stop: dead time first, then mode 1 and ramp to 64.
      send(1, 64);
      check("accept_busy", int'(busy), 0);
      step(1);
      check_dead(0);
      check("fwd_mode", int'(mode), 1);
      check("fwd_pwm0", int'(pwm), 0);
      expect_ramp(0, 64, 1);
      step(1);
      check("fwd_at_speed", int'(at_speed), 1);
      check("fwd_busy", int'(busy), 0);

      // Same-mode speed change up to 200 (final partial step), then back to 64.
      send(1, 200);
      step(1);
      check("up_busy", int'(busy), 1);
      expect_ramp(64, 200, 1);
      step(1);
      check("up_at_speed", int'(at_speed), 1);
      check("up_pwm", int'(pwm), 200);
      send(1, 64);
      step(1);
      expect_ramp(200, 64, 1);
      step(1);
      check("dn_at_speed", int'(at_speed), 1);

      // Reversal: ramp down, dead time in old mode, switch, ramp up.
      send(2, 64);
      step(1);
      check("rev_busy", int'(busy), 1);
      expect_ramp(64, 0, 1);
      step(1);
      check_dead(1);
      check("rev_mode", int'(mode), 2);
      expect_ramp(0, 64, 2);
      step(1);
      check("rev_at_speed", int'(at_speed), 1);

      // Mid-ramp replacement: target 160 replaced by 112 after reaching 96.
      send(2, 160);
      step(1);
      expect_ramp(64, 96, 2);
      send(2, 112);
      step(2);
      check("latest_hold", int'(pwm), 96);
      step(1);
      check("latest_pwm", int'(pwm), 112);
      step(1);
      check("latest_at_speed", int'(at_speed), 1);

      // Invalid mode 7 is a stop: ramp to 0, dead time, mode 0.
      send(7, 100);
      step(1);
      expect_ramp(112, 0, 2);
      step(1);
      check_dead(2);
      check("stop_mode", int'(mode), 0);
      check("stop_pwm", int'(pwm), 0);
      check("stop_busy", int'(busy), 0);
      check("stop_at_speed", int'(at_speed), 1);

      // Estop at pwm 48 for three cycles.
      send(1, 64);
      step(1);
      check_dead(0);
      expect_ramp(0, 48, 1);
      estop = 1'b1;
      #1;
      check("estop_ready", int'(cmd_ready), 0);
      step(1);
      check("estop_pwm", int'(pwm), 0);
      check("estop_mode", int'(mode), 0);
      check("estop_busy", int'(busy), 1);
      step(2);
      estop = 1'b0;
      check_dead(0);
      check("estop_hold_busy", int'(busy), 0);
      check("estop_hold_mode", int'(mode), 0);
      check("estop_at_speed", int'(at_speed), 1);

      // Asynchronous reset in the middle of a ramp.
      send(1, 64);
      step(1);
      check_dead(0);
      expect_ramp(0, 32, 1);
      reset = 1'b1;
      #1;
      check("arst_mode", int'(mode), 0);
      check("arst_pwm", int'(pwm), 0);
      check("arst_ready", int'(cmd_ready), 1);
      check("arst_busy", int'(busy), 0);
      check("arst_at_speed", int'(at_speed), 1);
      #2;
      reset = 1'b0;
      step(1);
      check("arst_post_busy", int'(busy), 0);
      check("arst_post_pwm", int'(pwm), 0);

`ifdef MOTION_RAMP_WATCHDOG_EN
      // Silence for WDT_CYCLES after the last command trips the watchdog.
      send(1, 64);
      step(1);
      check_dead(0);
      expect_ramp(0, 64, 1);
      step(1);
      step(WDT_CYCLES - 27);
      check("wdt_before", int'(wdt_trip), 0);
      step(1);
      check("wdt_fire", int'(wdt_trip), 1);
      step(1);
      check("wdt_down_busy", int'(busy), 1);
      expect_ramp(64, 0, 1);
      step(1);
      check_dead(1);
      check("wdt_mode", int'(mode), 0);
      check("wdt_busy", int'(busy), 0);
      check("wdt_sticky", int'(wdt_trip), 1);
      send(1, 64);
      check("wdt_clear", int'(wdt_trip), 0);
`else
      step(WDT_CYCLES + 50);
      check("wdt_tied_off", int'(wdt_trip), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
